fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (IF) stage of the MIPS-R2000 five-stage pipeline. It is the producer side of the IF/ID interface consumed by the decode stage. It owns the fetch PC and issues word reads to the instruction memory over a single-outstanding request/valid handshake. It registers the returned instruction into the IF/ID pipeline register and obeys decode's stall (`hold_pc`, `hold_if`), branch redirect (`br`, `pc_branch`) and exception redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `EXC_VECTOR`, default 32'h0000_0180: fetch address after `exception`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `hold_pc` in 1: from decode hazard unit; blocks issue of a new fetch request.
- `hold_if` in 1: from decode hazard unit; freezes IF/ID register.
- `br` in 1: branch taken, redirect to `pc_branch`.
- `pc_branch` in 32: branch target.
- `exception` in 1: redirect to `EXC_VECTOR`; priority over `br`.
- `imem_req` out 1: fetch request strobe, one cycle per request.
- `imem_addr` out 32: word address of request, equals internal `fpc`.
- `imem_valid` in 1: response strobe, ≥1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `inst_out` out 32: IF/ID instruction (feeds decode `inst_in`).
- `pc` out 32: IF/ID address of `inst_out` plus 4 (feeds decode `pc`).
- `if_valid` out 1: IF/ID holds a real instruction (0 = bubble).
- `flush_id` out 1: one-cycle pulse to decode on redirect.

## Operation
- NOP = 32'h0000_0000. Redirect = `exception | br`; target = `exception ? EXC_VECTOR : pc_branch`.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: outstanding response is to be discarded.
  - HELD: response captured in the skid register while `hold_if` is asserted.
- `imem_req = (state==IDLE) & !hold_pc & !redirect`; `imem_addr = fpc`.
- IDLE: if `imem_req` is asserted, go to WAIT.
- WAIT, on `imem_valid` with `!hold_if`:
  - IF/ID ← {`imem_rdata`, `fpc+4`, `if_valid`=1}.
  - `fpc` ← `fpc+4`.
  - Go to IDLE.
- WAIT, on `imem_valid` with `hold_if`: skid ← `imem_rdata`; `fpc` is unchanged; go to HELD.
- HELD, on `!hold_if`:
  - IF/ID ← {skid, `fpc+4`, 1}.
  - `fpc` ← `fpc+4`.
  - Go to IDLE. No refetch of the held address.
- Redirect, in any state:
  - `fpc` ← target.
  - `flush_id` = 1 next cycle.
  - IF/ID ← {NOP, 0, 0}, even when `hold_if` is asserted.
  - Skid is discarded.
  - Next state:
    - From WAIT without `imem_valid` in the same cycle, or from DROP: go to DROP.
    - From WAIT with `imem_valid` in the same cycle: the response is dropped; go to IDLE.
    - From IDLE or HELD: go to IDLE.
- DROP: on `imem_valid`, discard the response and go to IDLE. A further redirect in DROP only updates `fpc`.
- IF/ID not loaded and `hold_if`=0: load a bubble {NOP, 0, 0}, so decode never re-decodes a stale word.
- IF/ID not loaded and `hold_if`=1: IF/ID holds its value.
- `imem_valid` in IDLE or HELD is ignored (covers a response that arrives late after reset).
- Address arithmetic is 32-bit modulo; `fpc+4` wraps from 0xFFFF_FFFC to 0. No alignment checking.

## Timing
- Reset values:
  - `fpc` = `RESET_PC`; state = IDLE.
  - `inst_out` = 0, `pc` = 0, `if_valid` = 0, `flush_id` = 0.
  - Skid = 0.
  - `imem_req` = 1 in the first cycle after `rst` drops, unless `hold_pc` is asserted.
- Reset mid-operation: all state returns to reset values at the next edge. The outstanding response is ignored.
- Latency with a 1-cycle memory:
  - Cycle N: request issued.
  - Cycle N+1: `imem_valid` returned.
  - Cycle N+2: `inst_out` visible.
  - Cycle N+2: next request issued.
  - Throughput is one instruction per 2 cycles; each extra memory wait cycle adds one.
- `flush_id` is registered: high exactly one cycle after the redirect cycle, for one cycle per redirect.
- All outputs except `imem_req` and `imem_addr` are registered.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, WAIT, DROP, HELD}.
  - `NOP_INST` constant.
  - IF/ID struct {inst, pc, valid}.
- Sub-module `fetch_skid`: 32-bit capture register with load/clear and a full flag, used for the HELD state.
- Remaining logic (FSM, `fpc`, IF/ID register) lives in `fetch_stage`.

## Test plan
1. Reset, 1-cycle memory returning 32'h2001_0005 at address 0 → `imem_req` with addr 0 in the first cycle; two cycles later `inst_out`=32'h2001_0005, `pc`=4, `if_valid`=1; the next request uses addr 4.
2. `hold_if`=1 when `imem_valid` returns 0x8C22_0000 for addr 8 → `inst_out` holds its prior value. After release, `inst_out`=0x8C22_0000 and `pc`=12; addr 8 is never re-requested.
3. `br`=1, `pc_branch`=0x40 while in WAIT (response 2 cycles later) → `flush_id` pulses once; `inst_out`=0 and `if_valid`=0; the late response is dropped; the next request uses addr 0x40.
4. `exception`=1 and `br`=1 (`pc_branch`=0x40) in the same cycle → the next request uses addr 0x180.
5. `hold_pc`=1 for 3 cycles in IDLE → no `imem_req` during those cycles, `inst_out`=NOP; the request is issued the cycle `hold_pc` drops.
6. `rst` asserted in WAIT, with `imem_valid` arriving the cycle after → all outputs are at reset values; the response is ignored; the next request uses `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the IF stage: FSM state encoding, NOP word and the IF/ID register layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HELD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding instruction-memory handshake between the IF stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/fetch_skid.sv
// Capture register holding an imem response while decode stalls the IF/ID register.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS-R2000 instruction-fetch stage: owns the fetch PC, talks to imem, fills the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold_pc,
  input  logic                 hold_if,
  input  logic                 br,
  input  logic [31:0]          pc_branch,
  input  logic                 exception,
  fetch_stage_if.master        imem,
  output logic [31:0]          inst_out,
  output logic [31:0]          pc,
  output logic                 if_valid,
  output logic                 flush_id
);

  fetch_state_t state, state_nxt;
  if_id_t       ifid;
  logic [31:0]  fpc, fpc_inc, target, skid_q;
  logic         redirect, req_now, rsp_take, cap_now, skid_load, held_rel, skid_full;

  assign redirect  = exception | br;
  assign target    = exception ? EXC_VECTOR : pc_branch;
  assign fpc_inc   = fpc + 32'd4;
  assign req_now   = (state == IDLE) & ~hold_pc & ~redirect;
  assign rsp_take  = (state == WAIT) & imem.valid;
  assign cap_now   = rsp_take & ~hold_if & ~redirect;
  assign skid_load = rsp_take & hold_if & ~redirect;
  assign held_rel  = (state == HELD) & skid_full & ~hold_if & ~redirect;

  assign imem.req  = req_now;
  assign imem.addr = fpc;

  fetch_skid u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clr  (redirect | held_rel),
    .d    (imem.rdata),
    .q    (skid_q),
    .full (skid_full)
  );

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      // A response still in flight must be swallowed before issuing to the new target.
      case (state)
        WAIT:    state_nxt = imem.valid ? IDLE : DROP;
        DROP:    state_nxt = imem.valid ? IDLE : DROP;
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: if (req_now)    state_nxt = WAIT;
        WAIT: if (imem.valid) state_nxt = hold_if ? HELD : IDLE;
        HELD: if (!hold_if)   state_nxt = IDLE;
        DROP: if (imem.valid) state_nxt = IDLE;
        default:              state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      flush_id   <= 1'b0;
      ifid.inst  <= NOP_INST;
      ifid.pc    <= '0;
      ifid.valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      flush_id <= redirect;

      if (redirect)
        fpc <= target;
      else if (cap_now || held_rel)
        fpc <= fpc_inc;

      // Redirect bubbles IF/ID even under hold_if; otherwise an unloaded cycle
      // inserts a bubble unless decode is holding.
      if (redirect) begin
        ifid.inst  <= NOP_INST;
        ifid.pc    <= '0;
        ifid.valid <= 1'b0;
      end else if (cap_now) begin
        ifid.inst  <= imem.rdata;
        ifid.pc    <= fpc_inc;
        ifid.valid <= 1'b1;
      end else if (held_rel) begin
        ifid.inst  <= skid_q;
        ifid.pc    <= fpc_inc;
        ifid.valid <= 1'b1;
      end else if (!hold_if) begin
        ifid.inst  <= NOP_INST;
        ifid.pc    <= '0;
        ifid.valid <= 1'b0;
      end
    end
  end

  assign inst_out = ifid.inst;
  assign pc       = ifid.pc;
  assign if_valid = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays imem by hand, cycle by cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, hold_pc, hold_if, br, exception;
  logic [31:0] pc_branch;
  logic [31:0] inst_out, pc;
  logic        if_valid, flush_id;
  int          n_run  = 0;
  int          n_fail = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .hold_pc   (hold_pc),
    .hold_if   (hold_if),
    .br        (br),
    .pc_branch (pc_branch),
    .exception (exception),
    .imem      (imem),
    .inst_out  (inst_out),
    .pc        (pc),
    .if_valid  (if_valid),
    .flush_id  (flush_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; exception = 1'b0;
    pc_branch = '0; imem.valid = 1'b0; imem.rdata = '0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ifv", {31'b0, if_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush_id}, 32'h0);
    chk("rst_req", {31'b0, imem.req}, 32'h1);
    chk("rst_addr", imem.addr, 32'h0);

    // 1: one-cycle memory, first instruction
    step(); imem.valid = 1'b1; imem.rdata = 32'h2001_0005; #1;
    chk("t1_req_wait", {31'b0, imem.req}, 32'h0);
    step(); imem.valid = 1'b0; #1;
    chk("t1_inst", inst_out, 32'h2001_0005);
    chk("t1_pc", pc, 32'h4);
    chk("t1_ifv", {31'b0, if_valid}, 32'h1);
    chk("t1_req", {31'b0, imem.req}, 32'h1);
    chk("t1_addr", imem.addr, 32'h4);

    // 2: hold_if while the addr-8 response arrives
    step(); imem.valid = 1'b1; imem.rdata = 32'h0000_1111; #1;
    step(); imem.valid = 1'b0; hold_if = 1'b1; #1;
    chk("t2_addr8", imem.addr, 32'h8);
    chk("t2_req8", {31'b0, imem.req}, 32'h1);
    step(); imem.valid = 1'b1; imem.rdata = 32'h8C22_0000; #1;
    step(); imem.valid = 1'b0; #1;
    chk("t2_hold_inst", inst_out, 32'h0000_1111);
    chk("t2_hold_pc", pc, 32'h8);
    chk("t2_hold_req", {31'b0, imem.req}, 32'h0);
    step();
    chk("t2_hold2_inst", inst_out, 32'h0000_1111);
    chk("t2_hold2_req", {31'b0, imem.req}, 32'h0);
    hold_if = 1'b0; #1;
    step();
    chk("t2_rel_inst", inst_out, 32'h8C22_0000);
    chk("t2_rel_pc", pc, 32'hC);
    chk("t2_rel_ifv", {31'b0, if_valid}, 32'h1);
    chk("t2_rel_req", {31'b0, imem.req}, 32'h1);
    chk("t2_rel_addr", imem.addr, 32'hC);

    // 3: branch while WAIT, late response dropped
    step(); br = 1'b1; pc_branch = 32'h40; #1;
    chk("t3_req_br", {31'b0, imem.req}, 32'h0);
    step(); br = 1'b0; imem.valid = 1'b1; imem.rdata = 32'hDEAD_BEEF; #1;
    chk("t3_flush", {31'b0, flush_id}, 32'h1);
    chk("t3_inst", inst_out, 32'h0);
    chk("t3_ifv", {31'b0, if_valid}, 32'h0);
    chk("t3_req_drop", {31'b0, imem.req}, 32'h0);
    step(); imem.valid = 1'b0; #1;
    chk("t3_flush_off", {31'b0, flush_id}, 32'h0);
    chk("t3_drop_inst", inst_out, 32'h0);
    chk("t3_drop_ifv", {31'b0, if_valid}, 32'h0);
    chk("t3_req", {31'b0, imem.req}, 32'h1);
    chk("t3_addr", imem.addr, 32'h40);

    // 4: exception beats branch
    exception = 1'b1; br = 1'b1; pc_branch = 32'h40; #1;
    chk("t4_req_redir", {31'b0, imem.req}, 32'h0);
    step(); exception = 1'b0; br = 1'b0; #1;
    chk("t4_flush", {31'b0, flush_id}, 32'h1);
    chk("t4_req", {31'b0, imem.req}, 32'h1);
    chk("t4_addr", imem.addr, 32'h180);
    step(); imem.valid = 1'b1; imem.rdata = 32'h0000_1234; #1;
    chk("t4_flush_off", {31'b0, flush_id}, 32'h0);
    step(); imem.valid = 1'b0; #1;
    chk("t4_inst", inst_out, 32'h0000_1234);
    chk("t4_pc", pc, 32'h184);

    // 5: hold_pc for three cycles in IDLE
    hold_pc = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_req", {31'b0, imem.req}, 32'h0);
      step();
    end
    chk("t5_inst_nop", inst_out, 32'h0);
    chk("t5_ifv", {31'b0, if_valid}, 32'h0);
    hold_pc = 1'b0; #1;
    chk("t5_req", {31'b0, imem.req}, 32'h1);
    chk("t5_addr", imem.addr, 32'h184);

    // 6: reset while WAIT, stale response right after
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0; imem.valid = 1'b1; imem.rdata = 32'hFFFF_FFFF; #1;
    chk("t6_inst", inst_out, 32'h0);
    chk("t6_pc", pc, 32'h0);
    chk("t6_ifv", {31'b0, if_valid}, 32'h0);
    chk("t6_flush", {31'b0, flush_id}, 32'h0);
    chk("t6_req", {31'b0, imem.req}, 32'h1);
    chk("t6_addr", imem.addr, 32'h0);
    step(); imem.rdata = 32'hAAAA_0001; #1;
    chk("t6_stale_inst", inst_out, 32'h0);
    chk("t6_stale_ifv", {31'b0, if_valid}, 32'h0);
    step(); imem.valid = 1'b0; #1;
    chk("t6_new_inst", inst_out, 32'hAAAA_0001);
    chk("t6_new_pc", pc, 32'h4);

    // address wrap at the top of memory
    br = 1'b1; pc_branch = 32'hFFFF_FFFC; #1;
    step(); br = 1'b0; #1;
    chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    chk("wrap_req", {31'b0, imem.req}, 32'h1);
    step(); imem.valid = 1'b1; imem.rdata = 32'h5555_0000; #1;
    step(); imem.valid = 1'b0; #1;
    chk("wrap_inst", inst_out, 32'h5555_0000);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_next", imem.addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
